perf_counter_ctrl: RTL

//  Hardware performance-counter controller for the nontrivial_mips core. It shares NUM_CNT

---
 rtl/perf_counter_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: hardware performance-counter controller for the nontrivial_mips core.
// NUM_CNT programmable counters, each selecting one of NUM_EVT event sources (event 0 is
// a hard-wired "cycle" source that always contributes +1). Each source supplies a 0..3
// increment per cycle. Counters are programmed and read through a one-cycle register
// port. Overflows set sticky STATUS bits and can raise a level interrupt towards CP0.
//
// Register map (reg_addr):
//   0 CTRL {[3]ie, [2]clr (self-clearing, reads 0), [1]frz, [0]en}
//   1 STATUS {[NUM_CNT-1:0] ovf}, write-1-to-clear
//   2..5 SEL0..3 {[3:0] evt}
//   8..B CNT0..3
//   C..F SNAP0..3 (read-only, PERF_SNAPSHOT_EN builds only; otherwise read 0)
//   Unmapped or absent registers read 0 and ignore writes; every request is acked.
//
// Ports:
//   cpu_clk    core clock
//   resetn     synchronous, active-low reset
//   evt_inc    per-event increment, evt_inc[2e+1:2e] for event e
//   reg_req    register access strobe, one cycle per access
//   reg_we     1 = write, 0 = read
//   reg_addr   register index
//   reg_wdata  write data
//   snap       (PERF_SNAPSHOT_EN only) copy all counters into SNAP shadows
//   reg_ack    access done, exactly one cycle after reg_req
//   reg_rdata  read data, valid while reg_ack, 0 otherwise
//   perf_irq   level interrupt, |(STATUS.ovf & CTRL.ie)
//
// Optional feature macro: PERF_SNAPSHOT_EN (adds the snap input and SNAP registers).

module perf_counter_ctrl #(
   parameter int unsigned NUM_CNT = 4,
   parameter int unsigned NUM_EVT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 cpu_clk,
   input  logic                 resetn,
   input  logic [2*NUM_EVT-1:0] evt_inc,
   input  logic                 reg_req,
   input  logic                 reg_we,
   input  logic [3:0]           reg_addr,
   input  logic [31:0]          reg_wdata,
`ifdef PERF_SNAPSHOT_EN
   input  logic                 snap,
`endif
   output logic                 reg_ack,
   output logic [31:0]          reg_rdata,
   output logic                 perf_irq
);

   logic               ctrl_en_q, ctrl_frz_q, ctrl_ie_q;
   logic [NUM_CNT-1:0] ovf_q, ovf_d;
   logic [3:0]         sel_q [NUM_CNT];
   logic [CNT_W-1:0]   cnt_q [NUM_CNT];
   logic [CNT_W-1:0]   cnt_d [NUM_CNT];
   logic               ack_q;
   logic [31:0]        rdata_q, rdata_d;
`ifdef PERF_SNAPSHOT_EN
   logic [CNT_W-1:0]   snap_q [NUM_CNT];
`endif

   // Event 0 is the cycle source; the evt_inc slot for it is ignored.
   logic [1:0] evt_val [16];
   logic       unused_evt0;
   assign unused_evt0 = ^evt_inc[1:0];

   for (genvar e = 0; e < 16; e++) begin : g_evt
      if (e == 0) begin : g_cycle
         assign evt_val[e] = 2'd1;
      end else if (e < NUM_EVT) begin : g_src
         assign evt_val[e] = evt_inc[2*e +: 2];
      end else begin : g_none
         assign evt_val[e] = 2'd0;
      end
   end

   logic               wr_en, ctrl_wr, status_wr, clr, count_en, freeze_now;
   logic [NUM_CNT-1:0] cnt_wr, new_ovf;
   logic [CNT_W:0]     sum [NUM_CNT];

   assign wr_en     = reg_req & reg_we;
   assign ctrl_wr   = wr_en && (reg_addr == 4'd0);
   assign status_wr = wr_en && (reg_addr == 4'd1);
   assign clr       = ctrl_wr & reg_wdata[2];
   assign count_en  = ctrl_en_q & ~(ctrl_frz_q & (|ovf_q));

   always_comb begin
      new_ovf = '0;
      cnt_wr  = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         sum[i]     = {1'b0, cnt_q[i]} + {{(CNT_W-1){1'b0}}, evt_val[sel_q[i]]};
         cnt_wr[i]  = wr_en && (reg_addr == 4'(8 + i));
         // A direct write or a clear overrides this cycle's increment and its carry.
         new_ovf[i] = count_en & ~cnt_wr[i] & ~clr & sum[i][CNT_W];
      end
   end

   // Freeze bites in the same edge the overflow is recorded: everyone else holds.
   assign freeze_now = ctrl_frz_q & (|new_ovf);

   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (cnt_wr[i]) begin
            cnt_d[i] = reg_wdata[CNT_W-1:0];
         end else if (count_en && (!freeze_now || new_ovf[i])) begin
            cnt_d[i] = sum[i][CNT_W-1:0];
         end
      end
      if (clr) begin
         ovf_d = '0;
      end else begin
         // New overflow wins over a coincident W1C on the same bit.
         ovf_d = (ovf_q & ~(status_wr ? reg_wdata[NUM_CNT-1:0] : '0)) | new_ovf;
      end
   end

   // Read data is sampled from register state before this edge's update.
   always_comb begin
      rdata_d = '0;
      if (reg_req && !reg_we) begin
         if (reg_addr == 4'd0) rdata_d = {28'd0, ctrl_ie_q, 1'b0, ctrl_frz_q, ctrl_en_q};
         if (reg_addr == 4'd1) rdata_d[NUM_CNT-1:0] = ovf_q;
         for (int i = 0; i < NUM_CNT; i++) begin
            if (reg_addr == 4'(2 + i)) rdata_d = {28'd0, sel_q[i]};
            if (reg_addr == 4'(8 + i)) rdata_d = 32'(cnt_q[i]);
`ifdef PERF_SNAPSHOT_EN
            if (reg_addr == 4'(12 + i)) rdata_d = 32'(snap_q[i]);
`endif
         end
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!resetn) begin
         ctrl_en_q  <= 1'b0;
         ctrl_frz_q <= 1'b0;
         ctrl_ie_q  <= 1'b0;
         ovf_q      <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         for (int i = 0; i < NUM_CNT; i++) begin
            sel_q[i] <= '0;
            cnt_q[i] <= '0;
`ifdef PERF_SNAPSHOT_EN
            snap_q[i] <= '0;
`endif
         end
      end else begin
         if (ctrl_wr) begin
            ctrl_en_q  <= reg_wdata[0];
            ctrl_frz_q <= reg_wdata[1];
            ctrl_ie_q  <= reg_wdata[3];
         end
         ovf_q   <= ovf_d;
         ack_q   <= reg_req;
         rdata_q <= rdata_d;
         for (int i = 0; i < NUM_CNT; i++) begin
            if (wr_en && (reg_addr == 4'(2 + i))) sel_q[i] <= reg_wdata[3:0];
            cnt_q[i] <= cnt_d[i];
`ifdef PERF_SNAPSHOT_EN
            if (snap) snap_q[i] <= cnt_q[i];
`endif
         end
      end
   end

   assign reg_ack   = ack_q;
   assign reg_rdata = rdata_q;
   assign perf_irq  = ctrl_ie_q & (|ovf_q);

endmodule
